// File: rtl/cache_wb_buffer.sv
// Write-back buffer: queues evicted dirty blocks and drains them in FIFO order through
// the transfer unit's write-start / count-done handshake. Optional macro: WB_BUF_FWD_EN.
module cache_wb_buffer #(
   parameter int ADDR_WIDTH  = 64,
   parameter int BLOCK_WIDTH = 512,
   parameter int DEPTH       = 4
) (
   input  logic                     clk_i,
   input  logic                     arst_i,
   input  logic                     push_i,
   input  logic [ADDR_WIDTH-1:0]    push_addr_i,
   input  logic [BLOCK_WIDTH-1:0]   push_block_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   input  logic                     axi_done_i,
   output logic                     axi_write_start_o,
   output logic [ADDR_WIDTH-1:0]    axi_addr_o,
   output logic [BLOCK_WIDTH-1:0]   data_block_o,
   input  logic [ADDR_WIDTH-1:0]    lookup_addr_i,
   output logic                     lookup_hit_o,
   output logic [BLOCK_WIDTH-1:0]   lookup_block_o,
   output logic [1:0]               state_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q  [DEPTH];
   logic [BLOCK_WIDTH-1:0] block_q [DEPTH];
   logic [PW-1:0]          wp_q, rp_q;
   logic [CW-1:0]          count_q;
   logic                   overflow_q;
   logic                   start_q, start_d;
   logic [ADDR_WIDTH-1:0]  head_addr_q;
   logic [BLOCK_WIDTH-1:0] head_block_q;
   logic                   do_push, pop, load;

   assign count_o           = count_q;
   assign empty_o           = (count_q == CW'(0));
   assign full_o            = (count_q == CW'(DEPTH));
   assign overflow_o        = overflow_q;
   assign axi_write_start_o = start_q;
   assign axi_addr_o        = head_addr_q;
   assign data_block_o      = head_block_q;
   assign state_o           = state_q;

   // full_o is the registered occupancy, so a push while full is dropped even if the
   // head pops in the same cycle.
   assign do_push = push_i && !full_o;

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= '0;
            block_q[i] <= '0;
         end
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            addr_q[wp_q]  <= push_addr_i;
            block_q[wp_q] <= push_block_i;
            wp_q          <= wp_q + PW'(1);
         end
         if (pop) begin
            rp_q <= rp_q + PW'(1);
         end
         if (push_i && full_o) begin
            overflow_q <= 1'b1;
         end
         count_q <= count_q + CW'(do_push) - CW'(pop);
      end
   end

   // Handshake: start rises together with a freshly loaded head and stays high, with
   // address and data frozen, until the transfer unit pulses done for one cycle. The
   // entry is popped on that done; start then stays low for at least two cycles.
   always_comb begin
      state_d = state_q;
      start_d = start_q;
      load    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_o) begin
               state_d = S_WRITE;
               start_d = 1'b1;
               load    = 1'b1;
            end
         end
         S_WRITE: begin
            if (axi_done_i) begin
               state_d = S_GAP;
               start_d = 1'b0;
               pop     = 1'b1;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
            start_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         head_addr_q  <= '0;
         head_block_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         if (load) begin
            head_addr_q  <= addr_q[rp_q];
            head_block_q <= block_q[rp_q];
         end
      end
   end

`ifdef WB_BUF_FWD_EN
   logic [PW-1:0] idx;

   // Walk from oldest to newest valid entry; later matches override, so the newest wins.
   always_comb begin
      lookup_hit_o   = 1'b0;
      lookup_block_o = '0;
      idx            = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rp_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
            lookup_hit_o   = 1'b1;
            lookup_block_o = block_q[idx];
         end
      end
   end
`else
   logic unused_lookup;

   assign unused_lookup  = ^lookup_addr_i;
   assign lookup_hit_o   = 1'b0;
   assign lookup_block_o = '0;
`endif

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Scoreboard bench for cache_wb_buffer: pushes queue the expected head, a monitor checks
// each rising write start; directed checks cover occupancy, overflow, reset and lookup.
module tb_cache_wb_buffer;

   localparam int AW = 64;
   localparam int BW = 512;
   localparam int EW = AW + BW;

   logic          clk_i = 1'b0;
   logic          arst_i;
   logic          push_i;
   logic [AW-1:0] push_addr_i;
   logic [BW-1:0] push_block_i;
   logic          full_o, empty_o, overflow_o;
   logic [2:0]    count_o;
   logic          axi_done_i;
   logic          axi_write_start_o;
   logic [AW-1:0] axi_addr_o;
   logic [BW-1:0] data_block_o;
   logic [AW-1:0] lookup_addr_i;
   logic          lookup_hit_o;
   logic [BW-1:0] lookup_block_o;
   logic [1:0]    state_o;

   logic          auto_done, auto_pulse, man_done;
   int            done_delay;
   logic [EW-1:0] exp_q[$];
   int            n_chk = 0;
   int            n_fail = 0;

   assign axi_done_i = auto_pulse | man_done;

   cache_wb_buffer #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .DEPTH(4)) dut (
      .clk_i             (clk_i),
      .arst_i            (arst_i),
      .push_i            (push_i),
      .push_addr_i       (push_addr_i),
      .push_block_i      (push_block_i),
      .full_o            (full_o),
      .empty_o           (empty_o),
      .count_o           (count_o),
      .overflow_o        (overflow_o),
      .axi_done_i        (axi_done_i),
      .axi_write_start_o (axi_write_start_o),
      .axi_addr_o        (axi_addr_o),
      .data_block_o      (data_block_o),
      .lookup_addr_i     (lookup_addr_i),
      .lookup_hit_o      (lookup_hit_o),
      .lookup_block_o    (lookup_block_o),
      .state_o           (state_o)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_i = ~clk_i;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] mk_data(input logic [AW-1:0] a);
      return {8{a}};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      arst_i    = 1'b0;
      push_i    = 1'b0;
      man_done  = 1'b0;
      auto_done = 1'b0;
      @(negedge clk_i);
      exp_q.delete();
      @(negedge clk_i);
      arst_i = 1'b1;
   endtask

   // Called at a negedge; holds push for exactly one rising edge.
   task automatic push_one(input logic [AW-1:0] a, input logic [BW-1:0] d, input bit accept);
      push_i       = 1'b1;
      push_addr_i  = a;
      push_block_i = d;
      if (accept) exp_q.push_back({a, d});
      @(negedge clk_i);
      push_i = 1'b0;
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (!axi_write_start_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk(name, {63'd0, axi_write_start_o}, 64'd1);
   endtask

   task automatic wait_drained(input string name);
      int n = 0;
      while (!(empty_o && !axi_write_start_o && exp_q.size() == 0) && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      chk(name, {63'd0, empty_o && !axi_write_start_o}, 64'd1);
      chk({name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- done responder ----------------
   initial begin
      int wait_cnt;
      auto_pulse = 1'b0;
      wait_cnt   = 0;
      forever begin
         @(negedge clk_i);
         auto_pulse = 1'b0;
         if (auto_done && axi_write_start_o) begin
            wait_cnt++;
            if (wait_cnt >= done_delay) begin
               auto_pulse = 1'b1;
               wait_cnt   = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic          prev_start;
      int            low_run;
      logic [EW-1:0] exp, got;
      prev_start = 1'b0;
      low_run    = 99;
      forever begin
         @(negedge clk_i);
         if (axi_write_start_o && !prev_start) begin
            n_chk++;
            if (low_run < 2) begin
               n_fail++;
               $display("FAIL start_gap: start low %0d cycles, expected at least 2", low_run);
            end
            got = {axi_addr_o, data_block_o};
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_start: addr 0x%0h with empty scoreboard", axi_addr_o);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL drain_order: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                           got[EW-1:BW], got[BW-1:0], exp[EW-1:BW], exp[BW-1:0]);
               end
            end
         end
         low_run    = axi_write_start_o ? 0 : low_run + 1;
         prev_start = axi_write_start_o;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int hi;
      logic [BW-1:0] d1, d2;
      arst_i        = 1'b0;
      push_i        = 1'b0;
      push_addr_i   = '0;
      push_block_i  = '0;
      man_done      = 1'b0;
      auto_done     = 1'b0;
      done_delay    = 1;
      lookup_addr_i = '0;
      do_reset();

      // Reset state
      chk("rst_empty", {63'd0, empty_o}, 64'd1);
      chk("rst_full", {63'd0, full_o}, 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_overflow", {63'd0, overflow_o}, 64'd0);
      chk("rst_start", {63'd0, axi_write_start_o}, 64'd0);
      chk("rst_addr", axi_addr_o, 64'd0);
      chk_blk("rst_data", data_block_o, '0);
      chk("rst_hit", {63'd0, lookup_hit_o}, 64'd0);
      chk("rst_state", 64'(state_o), 64'd0);

      // 1: single entry, latency and done after 5 cycles of start
      auto_done  = 1'b1;
      done_delay = 5;
      push_one(64'h1000, {64{8'hAA}}, 1'b1);
      chk("t1_count_after_push", 64'(count_o), 64'd1);
      chk("t1_start_edge1", {63'd0, axi_write_start_o}, 64'd0);
      @(negedge clk_i);
      chk("t1_start_edge2", {63'd0, axi_write_start_o}, 64'd1);
      chk("t1_addr", axi_addr_o, 64'h1000);
      chk("t1_state_write", 64'(state_o), 64'd1);
      hi = 1;
      while (axi_write_start_o && hi < 40) begin
         @(negedge clk_i);
         if (axi_write_start_o) hi++;
      end
      chk("t1_start_high_cycles", 64'(hi), 64'd5);
      chk("t1_count_after_done", 64'(count_o), 64'd0);
      chk("t1_state_gap", 64'(state_o), 64'd2);
      @(negedge clk_i);
      chk("t1_state_idle", 64'(state_o), 64'd0);
      chk("t1_start_low", {63'd0, axi_write_start_o}, 64'd0);
      chk("t1_addr_hold", axi_addr_o, 64'h1000);

      // 2: fill to DEPTH with no done, then overflow
      do_reset();
      for (int i = 1; i <= 4; i++) push_one(64'(i * 'h100), mk_data(64'(i * 'h100)), 1'b1);
      chk("t2_full", {63'd0, full_o}, 64'd1);
      chk("t2_count", 64'(count_o), 64'd4);
      chk("t2_no_overflow_yet", {63'd0, overflow_o}, 64'd0);
      chk("t2_head_addr", axi_addr_o, 64'h100);
      push_one(64'h500, mk_data(64'h500), 1'b0);
      chk("t2_overflow", {63'd0, overflow_o}, 64'd1);
      chk("t2_count_after_drop", 64'(count_o), 64'd4);
      repeat (3) @(negedge clk_i);
      chk("t2_overflow_sticky", {63'd0, overflow_o}, 64'd1);
      chk("t2_head_stable", axi_addr_o, 64'h100);

      // 3: push while full together with done: push dropped, pop taken
      man_done = 1'b1;
      push_one(64'h500, mk_data(64'h500), 1'b0);
      man_done = 1'b0;
      chk("t3_count", 64'(count_o), 64'd3);
      chk("t3_full", {63'd0, full_o}, 64'd0);
      chk("t3_overflow", {63'd0, overflow_o}, 64'd1);
      done_delay = 2;
      auto_done  = 1'b1;
      wait_drained("t3_drain");

      // 4: simultaneous push and pop at count 2, pointers wrap over 8 entries
      auto_done = 1'b0;
      push_one(64'h1100, mk_data(64'h1100), 1'b1);
      push_one(64'h1200, mk_data(64'h1200), 1'b1);
      chk("t4_count2", 64'(count_o), 64'd2);
      wait_start("t4_start");
      man_done = 1'b1;
      push_one(64'h1300, mk_data(64'h1300), 1'b1);
      man_done = 1'b0;
      chk("t4_count_push_pop", 64'(count_o), 64'd2);
      done_delay = 1;
      auto_done  = 1'b1;
      push_one(64'h1400, mk_data(64'h1400), 1'b1);
      push_one(64'h1500, mk_data(64'h1500), 1'b1);
      wait_drained("t4_drain_a");
      for (int i = 6; i <= 8; i++) push_one(64'h1000 + 64'(i * 'h100), mk_data(64'h1000 + 64'(i * 'h100)), 1'b1);
      wait_drained("t4_drain_b");

      // 5: reset during WRITE with 3 entries
      do_reset();
      for (int i = 0; i < 3; i++) push_one(64'hA00 + 64'(i * 'h100), mk_data(64'hA00 + 64'(i * 'h100)), 1'b1);
      wait_start("t5_start");
      #2 arst_i = 1'b0;
      #1;
      chk("t5_start_async_drop", {63'd0, axi_write_start_o}, 64'd0);
      chk("t5_empty", {63'd0, empty_o}, 64'd1);
      chk("t5_count", 64'(count_o), 64'd0);
      exp_q.delete();
      @(negedge clk_i);
      arst_i = 1'b1;
      hi = 0;
      repeat (8) begin
         @(negedge clk_i);
         if (axi_write_start_o) hi++;
      end
      chk("t5_no_start_after_reset", 64'(hi), 64'd0);
      auto_done = 1'b1;
      push_one(64'hD00, mk_data(64'hD00), 1'b1);
      wait_drained("t5_drain");

      // 6: forwarding lookup
      auto_done     = 1'b0;
      d1            = {64{8'hD1}};
      d2            = {64{8'hD2}};
      lookup_addr_i = 64'h40;
      push_i        = 1'b1;
      push_addr_i   = 64'h40;
      push_block_i  = d1;
      exp_q.push_back({64'h40, d1});
      #1 chk("t6_same_cycle_hidden", {63'd0, lookup_hit_o}, 64'd0);
      @(negedge clk_i);
      push_i = 1'b0;
`ifdef WB_BUF_FWD_EN
      chk("t6_hit_d1", {63'd0, lookup_hit_o}, 64'd1);
      chk_blk("t6_block_d1", lookup_block_o, d1);
      @(negedge clk_i);
      chk("t6_head_in_write", {63'd0, axi_write_start_o}, 64'd1);
      chk("t6_hit_head", {63'd0, lookup_hit_o}, 64'd1);
      push_one(64'h40, d2, 1'b1);
      chk("t6_hit_newest", {63'd0, lookup_hit_o}, 64'd1);
      chk_blk("t6_block_newest", lookup_block_o, d2);
`else
      @(negedge clk_i);
      push_one(64'h40, d2, 1'b1);
      chk("t6_nofwd_hit", {63'd0, lookup_hit_o}, 64'd0);
      chk_blk("t6_nofwd_block", lookup_block_o, '0);
`endif
      lookup_addr_i = 64'h80;
      #1;
      chk("t6_miss_hit", {63'd0, lookup_hit_o}, 64'd0);
      chk_blk("t6_miss_block", lookup_block_o, '0);
      lookup_addr_i = 64'h40;
      auto_done     = 1'b1;
      wait_drained("t6_drain");
      chk("t6_hit_after_drain", {63'd0, lookup_hit_o}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
